// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate truth-table sweep controller.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } sweep_state_t;

  function automatic int unsigned ncomb(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  localparam logic [3:0] TT_AND2 = 4'b1000;

endpackage

// File: rtl/settle_timer.sv
// Settle-window counter: held at zero by clear, counts while enabled, flags the last hold cycle.
module settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntLast);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Walks a gate's inputs through every combination, samples its output after a settle
// window and checks it against a truth table, reporting a per-combination failure map.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2,
  parameter logic [(1 << N_IN)-1:0] EXPECT = TT_AND2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        result,
  output logic [N_IN-1:0]             in_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [N_IN:0]               err_cnt,
  output logic [ncomb(N_IN)-1:0]      fail_mask
);

  localparam int unsigned NCOMB = ncomb(N_IN);
  localparam int unsigned ErrW  = N_IN + 1;
  localparam logic [N_IN-1:0] IdxLast = N_IN'(NCOMB - 1);

  sweep_state_t     state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_IN-1:0]  in_vec_q, in_vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ErrW-1:0]  err_q, err_d;
  logic [NCOMB-1:0] mask_q, mask_d;
  logic             expire;
  logic             mismatch;

  // Counter sits at zero outside SETTLE so every hold window starts fresh.
  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q != StSettle),
    .en_i     (state_q == StSettle),
    .expire_o (expire)
  );

  assign mismatch = (result != EXPECT[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    in_vec_d = in_vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    mask_d   = mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d    = '0;
          in_vec_d = '0;
          err_d    = '0;
          mask_d   = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (expire) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          if (mismatch) begin
            mask_d[idx_q] = 1'b1;
            err_d         = err_q + ErrW'(1);
          end
          if (idx_q == IdxLast) begin
            // Verdict includes this final sample so it is valid alongside the done pulse.
            pass_d  = (err_d == '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            idx_d    = idx_q + N_IN'(1);
            in_vec_d = idx_d;
            state_d  = StSettle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      in_vec_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      in_vec_q <= in_vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
    end
  end

  assign in_vec    = in_vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: modelled gates drive result, a scoreboard holds each sweep's verdict.
module tb_gate_sweep_ctrl;

  localparam logic [3:0] EXP = 4'b1000;
  localparam int GAnd = 0, GOr = 1, GStuck1 = 2;

  typedef struct {
    int         lat;
    logic [2:0] err;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1, abort0, abort1, res0, res1;
  logic [1:0] iv0, iv1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;

  int   gate;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  function automatic logic gate_fn(input int g, input logic [1:0] v);
    case (g)
      GAnd:    return v[0] & v[1];
      GOr:     return v[0] | v[1];
      GStuck1: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb res0 = gate_fn(gate, iv0);
  always_comb res1 = gate_fn(gate, iv1);

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(2), .EXPECT(EXP)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .result(res0),
    .in_vec(iv0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_mask(mask0)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(EXP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .result(res1),
    .in_vec(iv1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which != 0) start1 = v;
    else start0 = v;
  endtask

  // One full sweep; repulse adds start pulses seen at edges 4, 12 and 13 that must be ignored.
  task automatic run_sweep(input int which, input int g, input bit repulse);
    int         s;
    int         lat;
    int         done_k;
    int         n_done;
    exp_t       e;
    logic [1:0] iv;
    logic       b, dn, ps;
    logic [2:0] er;
    logic [3:0] mk;
    s      = (which != 0) ? 1 : 2;
    lat    = 4 * (s + 1);
    done_k = -1;
    n_done = 0;
    gate   = g;
    e.lat  = lat;
    e.err  = '0;
    e.mask = '0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      if (gate_fn(g, v) != EXP[i]) begin
        e.mask[i] = 1'b1;
        e.err     = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    sb.push_back(e);

    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    for (int k = 0; k < lat + 12; k++) begin
      iv = (which != 0) ? iv1 : iv0;
      b  = (which != 0) ? busy1 : busy0;
      dn = (which != 0) ? done1 : done0;
      ps = (which != 0) ? pass1 : pass0;
      er = (which != 0) ? err1 : err0;
      mk = (which != 0) ? mask1 : mask0;
      if (k == 0) begin
        check_eq("start_clears_err", 32'(er), 32'd0);
        check_eq("start_clears_mask", 32'(mk), 32'd0);
        check_eq("start_clears_pass", 32'(ps), 32'd0);
      end
      if (k < lat && (k % (s + 1)) == 1) check_eq("in_vec_step", 32'(iv), 32'(k / (s + 1)));
      if (k == lat - 1) check_eq("busy_last", 32'(b), 32'd1);
      if (k == lat) check_eq("busy_drop", 32'(b), 32'd0);
      if (dn) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1 && sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("done_latency", 32'(done_k), 32'(e.lat));
        check_eq("err_cnt", 32'(er), 32'(e.err));
        check_eq("fail_mask", 32'(mk), 32'(e.mask));
        check_eq("pass", 32'(ps), 32'(e.pass));
      end
      if (repulse) set_start(which, (k == 3 || k == 11 || k == 12));
      @(posedge clk); #1;
    end
    set_start(which, 1'b0);
    check_eq("done_pulses", 32'(n_done), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("done_seen", 32'd0, 32'd1);
    end
  endtask

  task automatic abort_test();
    int         n_done;
    logic [1:0] v;
    logic [3:0] pmask;
    logic [2:0] perr;
    n_done = 0;
    gate   = GStuck1;
    pmask  = '0;
    perr   = '0;
    for (int i = 0; i < 2; i++) begin
      v = 2'(i);
      if (gate_fn(GStuck1, v) != EXP[i]) begin
        pmask[i] = 1'b1;
        perr     = perr + 3'd1;
      end
    end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (done0) n_done++;
      if (k == 7) begin
        check_eq("abort_in_vec", 32'(iv0), 32'd2);
        abort0 = 1'b1;
      end
      if (k == 8) begin
        abort0 = 1'b0;
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_err", 32'(err0), 32'(perr));
        check_eq("abort_mask", 32'(mask0), 32'(pmask));
      end
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", 32'(n_done), 32'd0);
    check_eq("abort_pass", 32'(pass0), 32'd0);
    check_eq("abort_err_held", 32'(err0), 32'(perr));
  endtask

  task automatic reset_test();
    gate   = GStuck1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_reset_err", 32'(err0), 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_in_vec", 32'(iv0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_done", 32'(done0), 32'd0);
    check_eq("rst_pass", 32'(pass0), 32'd0);
    check_eq("rst_err", 32'(err0), 32'd0);
    check_eq("rst_mask", 32'(mask0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    gate   = GAnd;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    abort0 = 1'b0;
    abort1 = 1'b0;
    #12;
    check_eq("reset_in_vec", 32'(iv0), 32'd0);
    check_eq("reset_busy", 32'(busy0), 32'd0);
    check_eq("reset_done", 32'(done0), 32'd0);
    check_eq("reset_pass", 32'(pass0), 32'd0);
    check_eq("reset_err", 32'(err0), 32'd0);
    check_eq("reset_mask", 32'(mask0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_sweep(0, GAnd, 1'b0);
    run_sweep(0, GOr, 1'b0);
    run_sweep(0, GStuck1, 1'b0);
    run_sweep(0, GAnd, 1'b0);
    run_sweep(0, GAnd, 1'b1);
    abort_test();
    reset_test();
    run_sweep(1, GAnd, 1'b0);
    run_sweep(1, GOr, 1'b0);
    run_sweep(0, GAnd, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
